// File: rtl/nvram_upload.sv
// nvram_upload: byte store for high-score/NVRAM data, shared between the
// game CPU (port A) and the HPS ioctl transfer interface (port B).
// Game writes arm a quiet-time counter; once the game has been idle long
// enough an upload request is pulsed so the HPS saves the image. The HPS can
// also restore (download) an image into the same store.
module nvram_upload #(
  parameter int          ADDR_W       = 10,
  parameter logic [7:0]  NV_INDEX     = 8'd4,
  parameter logic [23:0] QUIET_CYCLES = 24'd10_816_000,
  parameter int          RD_LAT       = 1
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [7:0]        cpu_din,
  input  logic              cpu_we,
  output logic [7:0]        cpu_dout,
  input  logic              ioctl_download,
  input  logic              ioctl_upload,
  input  logic [7:0]        ioctl_index,
  input  logic              ioctl_wr,
  input  logic              ioctl_rd,
  input  logic [24:0]       ioctl_addr,
  input  logic [7:0]        ioctl_dout,
  output logic [7:0]        ioctl_din,
  output logic              ioctl_wait,
  output logic              ioctl_upload_req,
  output logic              dirty
);

  localparam int          DEPTH      = 1 << ADDR_W;
  localparam logic [1:0]  LAT_LAST   = 2'(RD_LAT - 1);
  localparam logic [23:0] QUIET_LAST = QUIET_CYCLES - 24'd1;

  typedef enum logic [1:0] {
    UP_IDLE    = 2'd0,
    UP_FETCH   = 2'd1,
    UP_PRESENT = 2'd2
  } up_state_e;

  typedef enum logic [1:0] {
    RQ_CLEAN   = 2'd0,
    RQ_COUNT   = 2'd1,
    RQ_PENDING = 2'd2
  } rq_state_e;

  logic [7:0]        mem_q [DEPTH];
  logic [7:0]        cpu_dout_q;
  logic [7:0]        b_rdata_q;
  logic [ADDR_W-1:0] b_addr_s;

  logic sel_s;
  logic in_range_s;
  logic rst_wr_s;
  logic up_act_s;
  logic dn_act_s;
  logic up_fall_s;
  logic dn_fall_s;

  up_state_e         up_state_q, up_state_d;
  logic [1:0]        lat_q, lat_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              oor_q, oor_d;
  logic              wait_q, wait_d;
  logic [7:0]        din_q, din_d;

  rq_state_e   rq_q, rq_d;
  logic [23:0] cnt_q, cnt_d;
  logic        dirty_q, dirty_d;
  logic        req_q, req_d;
  logic        wr_dur_q, wr_dur_d;
  logic        up_act_q;
  logic        dn_act_q;

  assign sel_s      = (ioctl_index == NV_INDEX);
  assign in_range_s = ~|ioctl_addr[24:ADDR_W];
  assign rst_wr_s   = ioctl_download & sel_s & ioctl_wr & in_range_s;
  assign up_act_s   = ioctl_upload & sel_s;
  assign dn_act_s   = ioctl_download & sel_s;
  assign up_fall_s  = up_act_q & ~up_act_s;
  assign dn_fall_s  = dn_act_q & ~dn_act_s;

  // Port B reads the live HPS address while idle so a 1-cycle latency works,
  // then keeps re-reading the latched address while the fetch is pending.
  assign b_addr_s = (up_state_q == UP_FETCH) ? addr_q : ioctl_addr[ADDR_W-1:0];

  // Store writes; the restore write is last so it wins an address collision.
  always_ff @(posedge CLK) begin
    if (cpu_we) begin
      mem_q[cpu_addr] <= cpu_din;
    end
    if (rst_wr_s) begin
      mem_q[ioctl_addr[ADDR_W-1:0]] <= ioctl_dout;
    end
  end

  // Port B registered read data, feeding the upload data register.
  always_ff @(posedge CLK) begin
    b_rdata_q <= mem_q[b_addr_s];
  end

  // Port A registered read data (read-before-write), cleared by reset.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      cpu_dout_q <= 8'h00;
    end else begin
      cpu_dout_q <= mem_q[cpu_addr];
    end
  end

  // Upload FSM next state: accept a read, hold wait for RD_LAT cycles, present.
  always_comb begin
    up_state_d = up_state_q;
    lat_d      = lat_q;
    addr_d     = addr_q;
    oor_d      = oor_q;
    wait_d     = wait_q;
    din_d      = din_q;
    case (up_state_q)
      UP_IDLE, UP_PRESENT: begin
        if (up_act_s && ioctl_rd) begin
          up_state_d = UP_FETCH;
          addr_d     = ioctl_addr[ADDR_W-1:0];
          oor_d      = ~in_range_s;
          lat_d      = 2'd0;
          wait_d     = 1'b1;
        end else begin
          up_state_d = UP_IDLE;
          wait_d     = 1'b0;
        end
      end
      UP_FETCH: begin
        if (!ioctl_upload) begin
          up_state_d = UP_IDLE;
          wait_d     = 1'b0;
        end else if (lat_q == LAT_LAST) begin
          up_state_d = UP_PRESENT;
          wait_d     = 1'b0;
          din_d      = oor_q ? 8'hFF : b_rdata_q;
        end else begin
          lat_d = lat_q + 2'd1;
        end
      end
      default: begin
        up_state_d = UP_IDLE;
        wait_d     = 1'b0;
      end
    endcase
  end

  // Upload FSM state and output registers.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      up_state_q <= UP_IDLE;
      lat_q      <= 2'd0;
      addr_q     <= {ADDR_W{1'b0}};
      oor_q      <= 1'b0;
      wait_q     <= 1'b0;
      din_q      <= 8'h00;
    end else begin
      up_state_q <= up_state_d;
      lat_q      <= lat_d;
      addr_q     <= addr_d;
      oor_q      <= oor_d;
      wait_q     <= wait_d;
      din_q      <= din_d;
    end
  end

  // Request FSM next state: quiet-time counting, request pulse, save/restore tracking.
  always_comb begin
    rq_d     = rq_q;
    cnt_d    = cnt_q;
    dirty_d  = dirty_q;
    wr_dur_d = wr_dur_q;
    req_d    = 1'b0;
    case (rq_q)
      RQ_COUNT: begin
        if (cnt_q >= QUIET_LAST) begin
          if (!ioctl_upload && !ioctl_download) begin
            req_d = 1'b1;
            rq_d  = RQ_PENDING;
          end else begin
            cnt_d = QUIET_LAST;
          end
        end else begin
          cnt_d = cnt_q + 24'd1;
        end
      end
      RQ_CLEAN, RQ_PENDING: begin
        rq_d = rq_q;
      end
      default: begin
        rq_d  = RQ_CLEAN;
        cnt_d = 24'd0;
      end
    endcase

    if (cpu_we) begin
      // A game write always restarts the quiet period.
      dirty_d  = 1'b1;
      cnt_d    = 24'd0;
      rq_d     = RQ_COUNT;
      wr_dur_d = up_act_s;
    end else if (dn_fall_s) begin
      // A finished restore means the store matches the saved image.
      dirty_d  = 1'b0;
      cnt_d    = 24'd0;
      rq_d     = RQ_CLEAN;
      wr_dur_d = wr_dur_q & ~up_fall_s;
    end else if (up_fall_s && wr_dur_q) begin
      // The saved image missed writes made during the upload; save again.
      dirty_d  = 1'b1;
      cnt_d    = 24'd0;
      rq_d     = RQ_COUNT;
      wr_dur_d = 1'b0;
    end else if (up_fall_s && (rq_q == RQ_PENDING)) begin
      dirty_d  = 1'b0;
      rq_d     = RQ_CLEAN;
      wr_dur_d = 1'b0;
    end else begin
      wr_dur_d = wr_dur_q & ~up_fall_s;
    end
  end

  // Request FSM state, counter and output registers.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      rq_q     <= RQ_CLEAN;
      cnt_q    <= 24'd0;
      dirty_q  <= 1'b0;
      req_q    <= 1'b0;
      wr_dur_q <= 1'b0;
      up_act_q <= 1'b0;
      dn_act_q <= 1'b0;
    end else begin
      rq_q     <= rq_d;
      cnt_q    <= cnt_d;
      dirty_q  <= dirty_d;
      req_q    <= req_d;
      wr_dur_q <= wr_dur_d;
      up_act_q <= up_act_s;
      dn_act_q <= dn_act_s;
    end
  end

  assign cpu_dout         = cpu_dout_q;
  assign ioctl_din        = din_q;
  assign ioctl_wait       = wait_q;
  assign ioctl_upload_req = req_q;
  assign dirty            = dirty_q;

endmodule

// File: tb/tb_nvram_upload.sv
// tb_nvram_upload: randomized and directed stimulus for nvram_upload, checked
// every cycle against a transaction-level model of the store, the upload
// handshake and the quiet-time request rule.
module tb_nvram_upload;

  localparam int ADDR_W = 10;
  localparam int DEPTH  = 1024;
  localparam int RD_LAT = 2;
  localparam int QUIET  = 16;

  logic              CLK = 1'b0;
  logic              RESET = 1'b1;
  logic [ADDR_W-1:0] cpu_addr = '0;
  logic [7:0]        cpu_din = 8'h00;
  logic              cpu_we = 1'b0;
  logic [7:0]        cpu_dout;
  logic              ioctl_download = 1'b0;
  logic              ioctl_upload = 1'b0;
  logic [7:0]        ioctl_index = 8'd0;
  logic              ioctl_wr = 1'b0;
  logic              ioctl_rd = 1'b0;
  logic [24:0]       ioctl_addr = '0;
  logic [7:0]        ioctl_dout = 8'h00;
  logic [7:0]        ioctl_din;
  logic              ioctl_wait;
  logic              ioctl_upload_req;
  logic              dirty;

  int checks = 0;
  int errors = 0;

  always #5 CLK = ~CLK;

  nvram_upload #(
    .ADDR_W(ADDR_W), .NV_INDEX(8'd4), .QUIET_CYCLES(24'd16), .RD_LAT(RD_LAT)
  ) dut (
    .CLK(CLK), .RESET(RESET),
    .cpu_addr(cpu_addr), .cpu_din(cpu_din), .cpu_we(cpu_we), .cpu_dout(cpu_dout),
    .ioctl_download(ioctl_download), .ioctl_upload(ioctl_upload),
    .ioctl_index(ioctl_index), .ioctl_wr(ioctl_wr), .ioctl_rd(ioctl_rd),
    .ioctl_addr(ioctl_addr), .ioctl_dout(ioctl_dout), .ioctl_din(ioctl_din),
    .ioctl_wait(ioctl_wait), .ioctl_upload_req(ioctl_upload_req), .dirty(dirty)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic [7:0] mem_m [DEPTH];
  bit         known_m [DEPTH];
  logic [7:0] exp_dout = 8'h00, exp_din = 8'h00;
  bit         exp_dout_ok = 1'b0, exp_wait = 1'b0, exp_req = 1'b0, exp_dirty = 1'b0;
  bit         busy = 1'b0, f_oor = 1'b0;
  int         f_addr = 0, f_edge = 0;
  bit         owed = 1'b0, pending = 1'b0, wr_during = 1'b0, old_pending = 1'b0;
  bit         up_prev = 1'b0, dn_prev = 1'b0, up_now = 1'b0, dn_now = 1'b0;
  int         qstart = 0, edge_n = 0;

  // Model update on every clock edge from the inputs presented before it.
  always @(posedge CLK) begin
    edge_n++;
    up_now = ioctl_upload && (ioctl_index == 8'd4);
    dn_now = ioctl_download && (ioctl_index == 8'd4);
    if (RESET) begin
      exp_dout = 8'h00; exp_dout_ok = 1'b1; exp_din = 8'h00; exp_wait = 1'b0;
      exp_req = 1'b0; exp_dirty = 1'b0; busy = 1'b0; owed = 1'b0; pending = 1'b0;
      wr_during = 1'b0; up_prev = 1'b0; dn_prev = 1'b0;
    end else begin
      exp_dout    = mem_m[cpu_addr];
      exp_dout_ok = known_m[cpu_addr];
      // one upload byte transaction: wait for RD_LAT cycles, then the data
      if (busy) begin
        if (!ioctl_upload) begin
          busy = 1'b0; exp_wait = 1'b0;
        end else if (edge_n - f_edge == RD_LAT) begin
          busy = 1'b0; exp_wait = 1'b0;
          exp_din = f_oor ? 8'hFF : mem_m[f_addr];
        end
      end else if (up_now && ioctl_rd) begin
        busy = 1'b1; exp_wait = 1'b1; f_edge = edge_n;
        f_oor = (ioctl_addr >= 25'd1024);
        f_addr = int'(ioctl_addr[ADDR_W-1:0]);
      end
      // request owed once QUIET edges passed since the last write, while HPS idle
      old_pending = pending;
      exp_req = owed && (edge_n - qstart >= QUIET) && !ioctl_upload && !ioctl_download;
      if (exp_req) begin owed = 1'b0; pending = 1'b1; end
      if (up_prev && !up_now) begin
        if (wr_during) begin owed = 1'b1; qstart = edge_n; pending = 1'b0; exp_dirty = 1'b1; end
        else if (old_pending) begin exp_dirty = 1'b0; pending = 1'b0; end
        wr_during = 1'b0;
      end
      if (dn_prev && !dn_now) begin exp_dirty = 1'b0; owed = 1'b0; pending = 1'b0; end
      if (cpu_we) begin
        exp_dirty = 1'b1; owed = 1'b1; qstart = edge_n; pending = 1'b0;
        if (up_now) wr_during = 1'b1;
      end
      up_prev = up_now;
      dn_prev = dn_now;
    end
    if (cpu_we) begin mem_m[cpu_addr] = cpu_din; known_m[cpu_addr] = 1'b1; end
    if (dn_now && ioctl_wr && ioctl_addr < 25'd1024) begin
      mem_m[ioctl_addr[ADDR_W-1:0]] = ioctl_dout;
      known_m[ioctl_addr[ADDR_W-1:0]] = 1'b1;
    end
  end

  // Compare every output against the model midway through each cycle.
  always @(negedge CLK) begin
    chk("upload_req", 32'(ioctl_upload_req), 32'(exp_req));
    chk("ioctl_wait", 32'(ioctl_wait), 32'(exp_wait));
    chk("ioctl_din", 32'(ioctl_din), 32'(exp_din));
    chk("dirty", 32'(dirty), 32'(exp_dirty));
    if (exp_dout_ok) chk("cpu_dout", 32'(cpu_dout), 32'(exp_dout));
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick(input int n);
    repeat (n) @(posedge CLK);
    #1;
  endtask

  task automatic cpu_write(input logic [ADDR_W-1:0] a, input logic [7:0] d);
    cpu_addr = a; cpu_din = d; cpu_we = 1'b1;
    tick(1);
    cpu_we = 1'b0;
  endtask

  task automatic hps_read(input logic [24:0] a);
    ioctl_addr = a; ioctl_rd = 1'b1;
    tick(1);
    ioctl_rd = 1'b0;
    tick(RD_LAT);
  endtask

  // Counts cycles until the request pulse; a missing pulse leaves first at -1.
  task automatic wait_req(input int max, output int first, output int pulses);
    first = -1; pulses = 0;
    for (int k = 1; k <= max; k++) begin
      tick(1);
      if (ioctl_upload_req === 1'b1) begin
        pulses++;
        if (first < 0) first = k;
      end
    end
  endtask

  int first, pulses;

  initial begin
    // reset state
    tick(2);
    chk("rst_cpu_dout", 32'(cpu_dout), 32'h00);
    chk("rst_din", 32'(ioctl_din), 32'h00);
    chk("rst_wait", 32'(ioctl_wait), 32'h0);
    chk("rst_req", 32'(ioctl_upload_req), 32'h0);
    chk("rst_dirty", 32'(dirty), 32'h0);
    RESET = 1'b0;

    // restore 0x400 bytes 0..255 repeating, plus a dropped out-of-range byte
    ioctl_index = 8'd4; ioctl_download = 1'b1;
    for (int a = 0; a < DEPTH; a++) begin
      ioctl_addr = 25'(a); ioctl_dout = 8'(a); ioctl_wr = 1'b1;
      tick(1);
    end
    ioctl_addr = 25'h400; ioctl_dout = 8'h77;
    tick(1);
    ioctl_wr = 1'b0; ioctl_download = 1'b0;
    tick(1);
    cpu_addr = 10'h123; tick(1);
    chk("restore_123", 32'(cpu_dout), 32'h23);
    chk("restore_dirty", 32'(dirty), 32'h0);
    cpu_addr = 10'h000; tick(1);
    chk("restore_oor_drop", 32'(cpu_dout), 32'h00);

    // download for another index leaves the store alone
    ioctl_index = 8'd0; ioctl_download = 1'b1; ioctl_wr = 1'b1;
    ioctl_addr = 25'h123; ioctl_dout = 8'hEE;
    tick(3);
    ioctl_wr = 1'b0; ioctl_download = 1'b0; ioctl_index = 8'd4;
    cpu_addr = 10'h123; tick(2);
    chk("idx0_untouched", 32'(cpu_dout), 32'h23);

    RESET = 1'b1; tick(2); RESET = 1'b0;

    // game write then read back; request after 16 quiet cycles, once
    cpu_write(10'h010, 8'h5A);
    chk("wr_dirty", 32'(dirty), 32'h1);
    wait_req(40, first, pulses);
    chk("req_delay", 32'(first), 32'd16);
    chk("req_once", 32'(pulses), 32'd1);
    chk("rd_5a", 32'(cpu_dout), 32'h5A);

    // upload: wait high two cycles, then data; out-of-range reads 0xFF
    ioctl_upload = 1'b1; tick(1);
    ioctl_addr = 25'h010; ioctl_rd = 1'b1; tick(1); ioctl_rd = 1'b0;
    chk("up_wait_c1", 32'(ioctl_wait), 32'h1);
    tick(1);
    chk("up_wait_c2", 32'(ioctl_wait), 32'h1);
    tick(1);
    chk("up_wait_c3", 32'(ioctl_wait), 32'h0);
    chk("up_din_5a", 32'(ioctl_din), 32'h5A);
    hps_read(25'h400);
    chk("up_din_oor", 32'(ioctl_din), 32'hFF);
    ioctl_upload = 1'b0; tick(1);
    chk("up_clean", 32'(dirty), 32'h0);

    // game write during an upload keeps dirty and re-requests
    cpu_write(10'h020, 8'h33);
    wait_req(20, first, pulses);
    ioctl_upload = 1'b1; tick(2);
    cpu_write(10'h021, 8'h44);
    tick(3);
    ioctl_upload = 1'b0; tick(1);
    chk("wr_during_dirty", 32'(dirty), 32'h1);
    wait_req(40, first, pulses);
    chk("rereq_delay", 32'(first), 32'd16);
    chk("rereq_once", 32'(pulses), 32'd1);
    ioctl_upload = 1'b1; tick(2); ioctl_upload = 1'b0; tick(1);

    // collision: restore data beats game data at the same address
    ioctl_download = 1'b1; ioctl_wr = 1'b1; ioctl_addr = 25'h055; ioctl_dout = 8'hBB;
    cpu_addr = 10'h055; cpu_din = 8'hAA; cpu_we = 1'b1;
    tick(1);
    cpu_we = 1'b0; ioctl_wr = 1'b0; ioctl_download = 1'b0;
    tick(2);
    chk("collision", 32'(cpu_dout), 32'hBB);

    // randomized traffic against the model
    for (int it = 0; it < 150; it++) begin
      case ($urandom_range(0, 4))
        0: begin
          repeat ($urandom_range(1, 3)) cpu_write(10'($urandom), 8'($urandom));
        end
        1: begin
          cpu_addr = 10'($urandom); tick($urandom_range(1, 20));
        end
        2: begin
          ioctl_index = ($urandom_range(0, 3) != 0) ? 8'd4 : 8'd1;
          ioctl_upload = 1'b1; tick(1);
          repeat ($urandom_range(1, 3)) begin
            if ($urandom_range(0, 3) == 0) begin
              ioctl_addr = 25'(1024 + $urandom_range(0, 100000));
            end else begin
              ioctl_addr = 25'($urandom_range(0, DEPTH - 1));
            end
            if ($urandom_range(0, 5) == 0) begin
              ioctl_rd = 1'b1; tick(1); ioctl_rd = 1'b0;
              ioctl_upload = 1'b0; tick(1);
            end else begin
              hps_read(ioctl_addr);
            end
            if ($urandom_range(0, 2) == 0) cpu_write(10'($urandom), 8'($urandom));
          end
          ioctl_upload = 1'b0; tick(1);
          ioctl_index = 8'd4;
        end
        3: begin
          ioctl_index = ($urandom_range(0, 1) != 0) ? 8'd4 : 8'd0;
          ioctl_download = 1'b1;
          repeat ($urandom_range(1, 6)) begin
            ioctl_addr = 25'($urandom_range(0, 1100)); ioctl_dout = 8'($urandom);
            ioctl_wr = 1'b1;
            if ($urandom_range(0, 3) == 0) begin
              cpu_addr = ioctl_addr[ADDR_W-1:0]; cpu_din = 8'($urandom); cpu_we = 1'b1;
            end
            tick(1);
            cpu_we = 1'b0;
          end
          ioctl_wr = 1'b0; ioctl_download = 1'b0; tick(1);
          ioctl_index = 8'd4;
        end
        default: tick($urandom_range(20, 40));
      endcase
    end

    // reset mid-fetch clears wait at once
    tick(20);
    ioctl_index = 8'd4; ioctl_upload = 1'b1; tick(1);
    ioctl_addr = 25'h010; ioctl_rd = 1'b1; tick(1); ioctl_rd = 1'b0;
    chk("fetch_wait", 32'(ioctl_wait), 32'h1);
    RESET = 1'b1; tick(1);
    chk("rst_fetch_wait", 32'(ioctl_wait), 32'h0);
    RESET = 1'b0; ioctl_upload = 1'b0; tick(1);

    // reset mid-count suppresses the request; data survives
    cpu_write(10'h0A0, 8'h66);
    tick(5);
    RESET = 1'b1; tick(1); RESET = 1'b0;
    chk("rst_count_dirty", 32'(dirty), 32'h0);
    wait_req(30, first, pulses);
    chk("rst_no_req", 32'(pulses), 32'd0);
    cpu_addr = 10'h0A0; tick(1);
    chk("retain_0a0", 32'(cpu_dout), 32'h66);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
